fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_timeout_counter.sv | 28 ++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, field layout and FSM encoding for the fetch unit
package fetch_unit_pkg;

  localparam int WORD_WIDTH_DEFAULT     = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Instruction field layout: [15:12] op, [11:8] dst, [7:4] extra op, [3:0] src
  localparam int FIELD_WIDTH = 4;
  localparam int OP_LSB      = 12;
  localparam int DST_LSB     = 8;
  localparam int EXTRA_LSB   = 4;
  localparam int SRC_LSB     = 0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_OR     = 4'h4,
    OP_LOAD   = 4'h5,
    OP_STORE  = 4'h6,
    OP_BRANCH = 4'h7,
    OP_EXT    = 4'hF
  } opcode_t;

  localparam logic [3:0] EXTRA_NONE  = 4'h0;
  localparam logic [3:0] EXTRA_SHL   = 4'h1;
  localparam logic [3:0] EXTRA_SHR   = 4'h2;
  localparam logic [3:0] EXTRA_IMM   = 4'h3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  function automatic logic [FIELD_WIDTH-1:0] field_at(input logic [15:0] word, input int lsb);
    return word[lsb +: FIELD_WIDTH];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read port between fetch unit and memory
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
);
  logic                  memory_read_request;
  logic [WORD_WIDTH-1:0] memory_address;
  logic                  memory_read_valid;
  logic [WORD_WIDTH-1:0] memory_read_data;

  modport master (
    output memory_read_request,
    output memory_address,
    input  memory_read_valid,
    input  memory_read_data
  );

  modport slave (
    input  memory_read_request,
    input  memory_address,
    output memory_read_valid,
    output memory_read_data
  );
endinterface

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts unanswered wait cycles and flags the last allowed one
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear holds the count at zero while no read is outstanding
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th unanswered cycle so the read is dropped at that edge
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with jump redirect and read timeout
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_request,
  input  logic                  jump_enable,
  input  logic [WORD_WIDTH-1:0] jump_target,
  fetch_unit_if.master          mem,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic [3:0]            instruction_operation,
  output logic [3:0]            instruction_destination,
  output logic [3:0]            instruction_operation_extra,
  output logic [3:0]            instruction_source,
  output logic [WORD_WIDTH-1:0] program_counter,
  output logic                  fetch_done,
  output logic                  fetch_error
);

  fetch_state_t          state, state_next;
  logic [WORD_WIDTH-1:0] address, address_next;
  logic                  request, request_next;
  logic [WORD_WIDTH-1:0] pc_next, instruction_next;
  logic                  error_next;
  logic                  complete, complete_next;
  logic                  pending_valid, pending_valid_next;
  logic [WORD_WIDTH-1:0] pending_target, pending_target_next;
  logic                  timer_clear, timer_enable, timer_expired;
  logic                  redirect;
  logic [WORD_WIDTH-1:0] redirect_target;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // A jump arriving in the completing cycle is newer than any latched one, so it wins
  assign redirect        = jump_enable | pending_valid;
  assign redirect_target = jump_enable ? jump_target : pending_target;

  assign mem.memory_read_request = request;
  assign mem.memory_address      = address;

  assign instruction_operation       = field_at(instruction[15:0], OP_LSB);
  assign instruction_destination     = field_at(instruction[15:0], DST_LSB);
  assign instruction_operation_extra = field_at(instruction[15:0], EXTRA_LSB);
  assign instruction_source          = field_at(instruction[15:0], SRC_LSB);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-register decode for IDLE/WAIT
  always_comb begin
    state_next          = state;
    address_next        = address;
    request_next        = request;
    pc_next             = program_counter;
    instruction_next    = instruction;
    error_next          = fetch_error;
    complete_next       = 1'b0;
    pending_valid_next  = pending_valid;
    pending_target_next = pending_target;
    timer_clear         = 1'b0;
    timer_enable        = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_clear        = 1'b1;
        pending_valid_next = 1'b0;
        if (jump_enable) begin
          pc_next = jump_target;
        end
        if (fetch_request) begin
          address_next = jump_enable ? jump_target : program_counter;
          request_next = 1'b1;
          state_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_enable = !mem.memory_read_valid;
        if (jump_enable) begin
          pending_valid_next  = 1'b1;
          pending_target_next = jump_target;
        end
        if (mem.memory_read_valid) begin
          instruction_next   = mem.memory_read_data;
          request_next       = 1'b0;
          complete_next      = 1'b1;
          pending_valid_next = 1'b0;
          pc_next            = redirect ? redirect_target : address + 1'b1;
          state_next         = ST_IDLE;
        end else if (timer_expired) begin
          error_next         = 1'b1;
          request_next       = 1'b0;
          pending_valid_next = 1'b0;
          if (redirect) begin
            pc_next = redirect_target;
          end
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers; fetch_done trails the instruction update by one cycle via complete
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address         <= '0;
      request         <= 1'b0;
      program_counter <= '0;
      instruction     <= '0;
      fetch_error     <= 1'b0;
      complete        <= 1'b0;
      fetch_done      <= 1'b0;
      pending_valid   <= 1'b0;
      pending_target  <= '0;
    end else begin
      address         <= address_next;
      request         <= request_next;
      program_counter <= pc_next;
      instruction     <= instruction_next;
      fetch_error     <= error_next;
      complete        <= complete_next;
      fetch_done      <= complete;
      pending_valid   <= pending_valid_next;
      pending_target  <= pending_target_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_request = 1'b0;
  logic        jump_enable = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic [15:0] instruction, program_counter;
  logic [3:0]  instruction_operation, instruction_destination;
  logic [3:0]  instruction_operation_extra, instruction_source;
  logic        fetch_done, fetch_error;

  fetch_unit_if #(.WORD_WIDTH(16)) mem_bus ();

  fetch_unit #(.WORD_WIDTH(16), .TIMEOUT_CYCLES(255)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .fetch_request              (fetch_request),
    .jump_enable                (jump_enable),
    .jump_target                (jump_target),
    .mem                        (mem_bus),
    .instruction                (instruction),
    .instruction_operation      (instruction_operation),
    .instruction_destination    (instruction_destination),
    .instruction_operation_extra(instruction_operation_extra),
    .instruction_source         (instruction_source),
    .program_counter            (program_counter),
    .fetch_done                 (fetch_done),
    .fetch_error                (fetch_error)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding read, its age, the PC, and when done must pulse
  bit          m_busy, m_jump, m_err;
  int          m_waited, cyc, done_at;
  logic [15:0] m_addr, m_pc, m_instr, m_jump_target;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_jump = 0; m_err = 0; m_waited = 0;
      m_addr = 0; m_pc = 0; m_instr = 0; m_jump_target = 0;
      cyc = 0; done_at = -10;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (jump_enable) m_pc = jump_target;
        if (fetch_request) begin
          m_busy = 1; m_addr = m_pc; m_waited = 0; m_jump = 0;
        end
      end else begin
        if (jump_enable) begin
          m_jump = 1; m_jump_target = jump_target;
        end
        if (mem_bus.memory_read_valid) begin
          m_instr = mem_bus.memory_read_data;
          m_pc    = m_jump ? m_jump_target : m_addr + 16'd1;
          m_busy  = 0;
          done_at = cyc + 1;
        end else begin
          m_waited++;
          if (m_waited == 255) begin
            m_err  = 1;
            m_busy = 0;
            if (m_jump) m_pc = m_jump_target;
          end
        end
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clock) begin
    check("memory_read_request", mem_bus.memory_read_request, m_busy);
    check("memory_address", mem_bus.memory_address, m_addr);
    check("instruction", instruction, m_instr);
    check("instruction_operation", instruction_operation, m_instr[15:12]);
    check("instruction_destination", instruction_destination, m_instr[11:8]);
    check("instruction_operation_extra", instruction_operation_extra, m_instr[7:4]);
    check("instruction_source", instruction_source, m_instr[3:0]);
    check("program_counter", program_counter, m_pc);
    check("fetch_done", fetch_done, (cyc == done_at));
    check("fetch_error", fetch_error, m_err);
    if (fetch_done === 1'b1) done_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic read_data(input logic [15:0] data);
    mem_bus.memory_read_valid = 1'b1;
    mem_bus.memory_read_data  = data;
    tick(1);
    mem_bus.memory_read_valid = 1'b0;
    mem_bus.memory_read_data  = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.memory_read_valid = 1'b0;
    mem_bus.memory_read_data  = 16'h0000;
    tick(2);
    check("reset pc", program_counter, 16'h0000);
    check("reset request", mem_bus.memory_read_request, 1'b0);
    check("reset error", fetch_error, 1'b0);
    check("reset done", fetch_done, 1'b0);
    reset = 1'b1;

    // Basic fetch with minimum latency
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    check("t1 address", mem_bus.memory_address, 16'h0000);
    check("t1 request", mem_bus.memory_read_request, 1'b1);
    read_data(16'h5123);
    check("t1 done not yet", fetch_done, 1'b0);
    tick(1);
    check("t1 done pulse", fetch_done, 1'b1);
    tick(2);
    check("t1 op", instruction_operation, 4'h5);
    check("t1 dst", instruction_destination, 4'h1);
    check("t1 extra", instruction_operation_extra, 4'h2);
    check("t1 src", instruction_source, 4'h3);
    check("t1 pc", program_counter, 16'h0001);
    check("t1 done count", done_count, 1);

    // PC wrap at top of address space
    jump_enable = 1'b1; jump_target = 16'hFFFF;
    tick(1);
    jump_enable = 1'b0;
    check("t2 pc jumped", program_counter, 16'hFFFF);
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    read_data(16'hA7C2);
    tick(2);
    check("t2 pc wrap", program_counter, 16'h0000);
    check("t2 error", fetch_error, 1'b0);

    // Jump and fetch together in IDLE
    jump_enable = 1'b1; jump_target = 16'h0040; fetch_request = 1'b1;
    tick(1);
    jump_enable = 1'b0; fetch_request = 1'b0;
    check("t3 address", mem_bus.memory_address, 16'h0040);
    read_data(16'h2AB4);
    tick(2);
    check("t3 pc", program_counter, 16'h0041);

    // Jump latched during WAIT overrides increment
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    tick(1);
    jump_enable = 1'b1; jump_target = 16'h0100;
    tick(1);
    jump_enable = 1'b0;
    check("t4 address held", mem_bus.memory_address, 16'h0041);
    tick(1);
    check("t4 address held late", mem_bus.memory_address, 16'h0041);
    read_data(16'h1234);
    tick(2);
    check("t4 pc", program_counter, 16'h0100);
    check("t4 done count", done_count, 4);

    // Valid on the last allowed WAIT cycle is accepted
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    tick(254);
    read_data(16'hBEEF);
    tick(2);
    check("t6 error", fetch_error, 1'b0);
    check("t6 instruction", instruction, 16'hBEEF);
    check("t6 pc", program_counter, 16'h0101);

    // Timeout abandons the read
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    tick(254);
    check("t5 request before timeout", mem_bus.memory_read_request, 1'b1);
    tick(1);
    check("t5 error", fetch_error, 1'b1);
    check("t5 request", mem_bus.memory_read_request, 1'b0);
    tick(2);
    check("t5 pc", program_counter, 16'h0101);
    check("t5 done count", done_count, 5);
    read_data(16'hFFFF);
    tick(2);
    check("t5 late valid instr", instruction, 16'hBEEF);
    check("t5 late valid done", done_count, 5);

    // Reset during WAIT
    fetch_request = 1'b1;
    tick(1);
    fetch_request = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    check("t7 request", mem_bus.memory_read_request, 1'b0);
    check("t7 address", mem_bus.memory_address, 16'h0000);
    check("t7 pc", program_counter, 16'h0000);
    check("t7 error", fetch_error, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    read_data(16'h7777);
    tick(3);
    check("t7 instruction", instruction, 16'h0000);
    check("t7 pc after", program_counter, 16'h0000);
    check("t7 done count", done_count, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
